// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and seven-segment helpers for the arithmetic datapath
package arith_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_COMPUTE,
        ST_SHOW
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - one hex nibble to active-low seven-segment pattern
module hex7seg
    import arith_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/arith_datapath_unit.sv
// rtl/arith_datapath_unit.sv - bytewise operand loader, add/sub with overflow flag, hex display
module arith_datapath_unit
    import arith_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_OVF = 1'b1,
    localparam int NWIN      = (WIDTH + 15) / 16,
    localparam int DSW       = (NWIN > 1) ? $clog2(NWIN) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enter,
    input  logic [7:0]     inputdata,
    input  logic           loaddata,
    input  logic           op,
    input  logic [DSW-1:0] dispsel,
    output logic           inputdata_ready,
    output logic           result_valid,
    output logic           flag,
    output logic [6:0]     disp3,
    output logic [6:0]     disp2,
    output logic [6:0]     disp1,
    output logic [6:0]     disp0
);

    localparam int NB = WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = NWIN * 16;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic             flag_q, flag_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             enter_q, enter_d;

    logic             enter_rise;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] r_next;
    logic             ovf;

    always_comb begin
        enter_rise = enter & ~enter_q;
        sum_ext    = {1'b0, a_q} + {1'b0, b_q};
        diff_ext   = {1'b0, a_q} - {1'b0, b_q};
        r_next     = op ? diff_ext[WIDTH-1:0] : sum_ext[WIDTH-1:0];
        if (SIGNED_OVF) begin
            if (op)
                ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (r_next[WIDTH-1] != a_q[WIDTH-1]);
            else
                ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_next[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
            // Top bit of the zero-extended difference is the borrow out
            ovf = op ? diff_ext[WIDTH] : sum_ext[WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        flag_d  = flag_q;
        valid_d = valid_q;
        enter_d = enter;

        // loaddata restarts from any state except the one-cycle COMPUTE
        if (loaddata && state_q != ST_COMPUTE) begin
            state_d = ST_LOAD_A;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_A: if (enter_rise) begin
                    a_d[32'(cnt_q)*8 +: 8] = inputdata;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOAD_B: if (enter_rise) begin
                    b_d[32'(cnt_q)*8 +: 8] = inputdata;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = ST_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    r_d     = r_next;
                    flag_d  = ovf;
                    state_d = ST_SHOW;
                end
                ST_SHOW: valid_d = 1'b1;
                default: state_d = state_q;
            endcase
        end

        ready_d = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            flag_q  <= flag_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            enter_q <= enter_d;
        end
    end

    assign inputdata_ready = ready_q;
    assign result_valid    = valid_q;
    assign flag            = flag_q;

    logic [PW-1:0]    disp_src;
    logic [DSW-1:0]   win_sel;
    logic [15:0]      win;
    logic             blank;
    logic [6:0]       seg3, seg2, seg1, seg0;

    always_comb begin
        disp_src = '0;
        if (valid_q)
            disp_src[WIDTH-1:0] = r_q;
        else if (state_q == ST_LOAD_A)
            disp_src[WIDTH-1:0] = a_q;
        else
            disp_src[WIDTH-1:0] = b_q;
        win_sel = (32'(dispsel) < NWIN) ? dispsel : '0;
        win     = disp_src[32'(win_sel)*16 +: 16];
        blank   = (state_q == ST_IDLE);
    end

    hex7seg u_seg3 (.nibble(win[15:12]), .seg(seg3));
    hex7seg u_seg2 (.nibble(win[11:8]),  .seg(seg2));
    hex7seg u_seg1 (.nibble(win[7:4]),   .seg(seg1));
    hex7seg u_seg0 (.nibble(win[3:0]),   .seg(seg0));

    assign disp3 = blank ? SEG_BLANK : seg3;
    assign disp2 = blank ? SEG_BLANK : seg2;
    assign disp1 = blank ? SEG_BLANK : seg1;
    assign disp0 = blank ? SEG_BLANK : seg0;

endmodule

// File: tb/tb_arith_datapath_unit.sv
// tb/tb_arith_datapath_unit.sv - directed-vector bench for arith_datapath_unit
module tb_arith_datapath_unit;

    localparam logic [6:0] S0 = 7'h40, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19, S5 = 7'h12;
    localparam logic [6:0] S8 = 7'h00, SE = 7'h06, SF = 7'h0E, SB = 7'h7F;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enter = 1'b0;
    logic [7:0] inputdata = 8'h00;
    logic       loaddata = 1'b0;
    logic       op = 1'b0;
    logic [0:0] dispsel = 1'b0;

    logic       ready_s, valid_s, flag_s;
    logic [6:0] d3_s, d2_s, d1_s, d0_s;
    logic       ready_u, valid_u, flag_u;
    logic [6:0] d3_u, d2_u, d1_u, d0_u;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arith_datapath_unit #(.WIDTH(32), .SIGNED_OVF(1'b1)) dut (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
        .loaddata(loaddata), .op(op), .dispsel(dispsel),
        .inputdata_ready(ready_s), .result_valid(valid_s), .flag(flag_s),
        .disp3(d3_s), .disp2(d2_s), .disp1(d1_s), .disp0(d0_s)
    );

    arith_datapath_unit #(.WIDTH(32), .SIGNED_OVF(1'b0)) dut_u (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
        .loaddata(loaddata), .op(op), .dispsel(dispsel),
        .inputdata_ready(ready_u), .result_valid(valid_u), .flag(flag_u),
        .disp3(d3_u), .disp2(d2_u), .disp1(d1_u), .disp0(d0_u)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] segs(input logic [6:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    task automatic press(input logic [7:0] value);
        inputdata = value;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    task automatic start_load(input logic opv);
        op = opv;
        loaddata = 1'b1;
        tick();
        loaddata = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic opv);
        start_load(opv);
        for (int i = 0; i < 4; i++) press(a[i*8 +: 8]);
        for (int i = 0; i < 3; i++) press(b[i*8 +: 8]);
        inputdata = b[31:24];
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check({tag, "_valid_e0"}, valid_s, 1'b0);
        tick();
        check({tag, "_valid_e1"}, valid_s, 1'b0);
        tick();
        check({tag, "_valid_e2"}, valid_s, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check("rst_ready", ready_s, 1'b0);
        check("rst_valid", valid_s, 1'b0);
        check("rst_flag", flag_s, 1'b0);
        check("rst_disp", {d3_s, d2_s, d1_s, d0_s}, segs(SB, SB, SB, SB));
        reset = 1'b1;
        tick();
        check("idle_disp", {d3_s, d2_s, d1_s, d0_s}, segs(SB, SB, SB, SB));

        start_load(1'b0);
        check("load_ready", ready_s, 1'b1);
        check("load_disp", {d3_s, d2_s, d1_s, d0_s}, segs(S0, S0, S0, S0));
        tick();

        run_op("add5_3", 32'h0000_0005, 32'h0000_0003, 1'b0);
        check("add5_3_ready", ready_s, 1'b0);
        check("add5_3_flag", flag_s, 1'b0);
        check("add5_3_uflag", flag_u, 1'b0);
        dispsel = 1'b0; #1;
        check("add5_3_win0", {d3_s, d2_s, d1_s, d0_s}, segs(S0, S0, S0, S8));
        dispsel = 1'b1; #1;
        check("add5_3_win1", {d3_s, d2_s, d1_s, d0_s}, segs(S0, S0, S0, S0));
        dispsel = 1'b0;

        run_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("ovf_flag", flag_s, 1'b1);
        check("ovf_uflag", flag_u, 1'b0);
        dispsel = 1'b1; #1;
        check("ovf_win1", {d3_s, d2_s, d1_s, d0_s}, segs(S8, S0, S0, S0));
        dispsel = 1'b0; #1;
        check("ovf_win0", {d3_s, d2_s, d1_s, d0_s}, segs(S0, S0, S0, S0));

        run_op("sub3_5", 32'h0000_0003, 32'h0000_0005, 1'b1);
        check("sub3_5_flag", flag_s, 1'b0);
        check("sub3_5_uflag", flag_u, 1'b1);
        check("sub3_5_win0", {d3_s, d2_s, d1_s, d0_s}, segs(SF, SF, SF, SE));
        dispsel = 1'b1; #1;
        check("sub3_5_win1", {d3_s, d2_s, d1_s, d0_s}, segs(SF, SF, SF, SF));
        dispsel = 1'b0;

        for (int k = 0; k < 3; k++) press(8'hAA);
        check("show_enter_valid", valid_s, 1'b1);
        check("show_enter_disp", {d3_s, d2_s, d1_s, d0_s}, segs(SF, SF, SF, SE));

        start_load(1'b0);
        for (int i = 0; i < 5; i++) press(8'h11);
        reset = 1'b0;
        tick();
        check("midrst_ready", ready_s, 1'b0);
        check("midrst_valid", valid_s, 1'b0);
        check("midrst_uflag", flag_u, 1'b0);
        check("midrst_disp", {d3_s, d2_s, d1_s, d0_s}, segs(SB, SB, SB, SB));
        reset = 1'b1;
        tick();
        run_op("fresh", 32'h0000_1234, 32'h0000_1111, 1'b0);
        check("fresh_disp", {d3_s, d2_s, d1_s, d0_s}, segs(S2, S3, S4, S5));

        start_load(1'b0);
        inputdata = 8'h05;
        enter = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        enter = 1'b0;
        tick();
        check("hold_ready", ready_s, 1'b1);
        check("hold_disp", {d3_s, d2_s, d1_s, d0_s}, segs(S0, S0, S0, S5));
        for (int i = 0; i < 3; i++) press(8'h00);
        press(8'h01);
        for (int i = 0; i < 3; i++) press(8'h00);
        for (int i = 0; i < 3; i++) tick();
        check("hold_result", {d3_s, d2_s, d1_s, d0_s}, segs(S0, S0, S0, 7'h02));

        start_load(1'b1);
        for (int i = 0; i < 4; i++) press(8'h33);
        press(8'h44);
        inputdata = 8'h55;
        enter = 1'b1;
        loaddata = 1'b1;
        tick();
        enter = 1'b0;
        loaddata = 1'b0;
        tick();
        check("restart_ready", ready_s, 1'b1);
        check("restart_disp", {d3_s, d2_s, d1_s, d0_s}, segs(S0, S0, S0, S0));
        press(8'h0F);
        check("restart_byte0", {d3_s, d2_s, d1_s, d0_s}, segs(S0, S0, S0, SF));
        for (int i = 0; i < 3; i++) press(8'h00);
        press(8'h01);
        for (int i = 0; i < 3; i++) press(8'h00);
        for (int i = 0; i < 3; i++) tick();
        check("restart_valid", valid_s, 1'b1);
        check("restart_result", {d3_s, d2_s, d1_s, d0_s}, segs(S0, S0, S0, SE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arith_datapath_unit.md
ARITH_DATAPATH_UNIT -- requirements
Module: arith_datapath_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter SIGNED_OVF, default 1, 1 = two's-complement overflow flag, 0 = unsigned carry/borrow flag.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset.
REQ-005 Port enter  input  1  byte-commit strobe (level, may last many cycles).
REQ-006 Port inputdata  input  8  operand byte.
REQ-007 Port loaddata  input  1  start/restart operand loading.
REQ-008 Port op  input  1  0 = A+B, 1 = A-B; sampled at COMPUTE.
REQ-009 Port dispsel  input  $clog2(WIDTH/16 max 1)  selects 16-bit result window for display.
REQ-010 Port inputdata_ready  output  1  block accepts a byte.
REQ-011 Port result_valid  output  1  result registers hold a completed result.
REQ-012 Port flag  output  1  overflow/carry per SIGNED_OVF.
REQ-013 Ports disp3, disp2, disp1, disp0  output  7 each  active-low segments {g..a}, disp0 = least significant nibble.

Function
REQ-014 enter SHALL be rising-edge detected internally; one commit per low-to-high transition, regardless of high duration.
REQ-015 FSM states IDLE, LOAD_A, LOAD_B, COMPUTE, SHOW.
REQ-016 IDLE/SHOW: loaddata=1 -> LOAD_A, byte counter cleared, A and B cleared, result_valid cleared.
REQ-017 LOAD_A: each enter edge writes inputdata into A byte[cnt], LSB-first, cnt++; after byte WIDTH/8-1 -> LOAD_B, cnt=0.
REQ-018 LOAD_B: same rule into B; after last byte -> COMPUTE.
REQ-019 COMPUTE: one cycle; R <= A+B or A-B (modulo 2^WIDTH), flag registered, op sampled this cycle; -> SHOW next cycle.
REQ-020 SHOW: result_valid=1; R, flag held until next loaddata or reset.
REQ-021 inputdata_ready SHALL equal 1 exactly in LOAD_A and LOAD_B.
REQ-022 Latency: result_valid asserts 2 cycles after the clock edge that commits the final B byte.
REQ-023 loaddata while in LOAD_A/LOAD_B SHALL restart at LOAD_A, byte 0, operands cleared; loaddata has priority over a simultaneous enter edge.
REQ-024 enter edges in IDLE, COMPUTE, SHOW SHALL be ignored.
REQ-025 Signed flag: add -> sign(A)=sign(B)≠sign(R); sub -> sign(A)≠sign(B) and sign(R)≠sign(A). Unsigned flag: carry-out on add, borrow (A<B) on sub.
REQ-026 Displays show hex nibbles of R[16*dispsel+15 : 16*dispsel] when result_valid=1; otherwise show the operand being loaded (A in LOAD_A, B in LOAD_B, same window); IDLE shows blank (all segments off, 7'h7F).
REQ-027 Out-of-range dispsel SHALL wrap to window 0.

Reset
REQ-028 reset=0 at a clock edge: state=IDLE, A=B=R=0, cnt=0, flag=0, result_valid=0, inputdata_ready=0, edge-detector history=0, displays blank; effective mid-operation in any state.

Structure
REQ-029 Shared package arith_pkg: state enum, blank/segment constants, hex-to-segment lookup function.
REQ-030 One sub-module hex7seg (4-bit nibble -> 7-bit active-low segments), instantiated four times.
REQ-031 Adder/subtractor, FSM, byte loader, flag logic in the top module; no latches, all outputs registered except segment decode.

Verification (WIDTH=32, SIGNED_OVF=1)
REQ-032 Load A=0x00000005, B=0x00000003, op=0 -> R=0x00000008, flag=0, disp0="8", disp1..3="0", result_valid 2 cycles after last enter.
REQ-033 A=0x7FFFFFFF, B=0x00000001, op=0 -> R=0x80000000, flag=1; dispsel=1 shows "8000".
REQ-034 A=0x00000003, B=0x00000005, op=1 -> R=0xFFFFFFFE, flag=0; rerun SIGNED_OVF=0 -> flag=1.
REQ-035 enter held high 10 cycles -> exactly one byte committed; enter in SHOW -> R unchanged.
REQ-036 reset=0 after 5 of 8 bytes -> all outputs at reset values next edge; fresh load then yields correct result.
REQ-037 loaddata and enter edge same cycle during LOAD_B -> state LOAD_A, cnt=0, byte discarded.
